shot_arbiter: RTL and testbench

//  Shares the bullet engine's NUM_SLOTS bullet slots between player 1 and player 2.
//  Per player: edge-detects and latches shoot presses, enforces a frame-based cooldown
//  and an in-flight limit. Round-robin arbitration between players.

---
 rtl/game_pkg.sv | 21 ++
 rtl/shot_cooldown.sv | 34 +++
 rtl/shot_arbiter.sv | 157 +++++++++++++++
 tb/tb_shot_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and default sizing
// Purpose: player and shot-arbiter state encodings plus default parameters
//          used by the shot arbiter and its cooldown counters.
// Ports:   none (package)
package game_pkg;

  typedef enum logic {
    PLAYER_1 = 1'b0,
    PLAYER_2 = 1'b1
  } player_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } shot_arb_state_e;

  localparam int NUM_SLOTS_DEF       = 4;
  localparam int COOLDOWN_FRAMES_DEF = 20;
  localparam int MAX_PER_PLAYER_DEF  = 2;

endpackage

// File: rtl/shot_cooldown.sv
// rtl/shot_cooldown.sv - per-player frame cooldown down-counter
// Purpose: loads FRAMES on a launch, counts down on frame ticks, saturates at 0.
// Ports:
//   clk_i     in  system clock
//   reset_i   in  synchronous active-high reset
//   load_i    in  launch accepted; reload counter (wins over tick)
//   tick_i    in  frame tick; decrement when nonzero
//   active_o  out counter nonzero
module shot_cooldown #(
  parameter int FRAMES = 20,
  parameter int CNT_W  = $clog2(FRAMES + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic tick_i,
  output logic active_o
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= CNT_W'(FRAMES);
    end else if (tick_i && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign active_o = (r_count != '0);

endmodule

// File: rtl/shot_arbiter.sv
// rtl/shot_arbiter.sv - shares bullet slots between two players
// Purpose: captures shoot presses, applies cooldown and in-flight limits,
//          round-robin arbitrates and offers one launch at a time.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   enable_i                playing; low drops pending presses
//   frame_tick_i            per-frame pulse for cooldowns
//   player_1/2_shoot_i      shoot keys (level)
//   retire_valid_i/slot_i   bullet engine frees a slot
//   launch_ready_i          bullet engine takes the offer
//   launch_valid_o/player_o/slot_o  launch offer
//   slot_busy_o             per-slot occupancy
//   cooldown_active_o       [0] P1, [1] P2 cooling down
module shot_arbiter
  import game_pkg::*;
#(
  parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
  parameter int SLOT_W          = $clog2(NUM_SLOTS),
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int MAX_PER_PLAYER  = MAX_PER_PLAYER_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 frame_tick_i,
  input  logic                 player_1_shoot_i,
  input  logic                 player_2_shoot_i,
  input  logic                 retire_valid_i,
  input  logic [SLOT_W-1:0]    retire_slot_i,
  input  logic                 launch_ready_i,
  output logic                 launch_valid_o,
  output logic                 launch_player_o,
  output logic [SLOT_W-1:0]    launch_slot_o,
  output logic [NUM_SLOTS-1:0] slot_busy_o,
  output logic [1:0]           cooldown_active_o
);

  localparam int IW = $clog2(MAX_PER_PLAYER + 1);

  shot_arb_state_e     r_state, w_state_next;
  player_e             r_player, r_last_grant, w_winner;
  logic [SLOT_W-1:0]   r_slot, w_free_slot;
  logic [1:0]          r_shoot_q, r_shoot_qq, r_pending;
  logic [NUM_SLOTS-1:0] r_busy, r_owner;
  logic [IW-1:0]       r_inflight [2];
  logic [1:0]          w_rise, w_eligible, w_inc, w_dec, w_cool_active;
  logic                w_accept, w_retire, w_any_free, w_load_offer;

  // Keys are registered twice so the edge is taken from synchronous samples.
  assign w_rise   = r_shoot_q & ~r_shoot_qq;
  assign w_accept = (r_state == OFFER) && launch_ready_i;
  // Retiring a slot that is not busy must not touch any in-flight count.
  assign w_retire   = retire_valid_i && r_busy[retire_slot_i];
  assign w_any_free = ~&r_busy;

  always_comb begin
    w_free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_slot = SLOT_W'(i);
    end
  end

  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    w_eligible = '0;
    for (int p = 0; p < 2; p++) begin
      w_inc[p]      = w_accept && (r_player == player_e'(p));
      w_dec[p]      = w_retire && (r_owner[retire_slot_i] == 1'(p));
      w_eligible[p] = r_pending[p] && !w_cool_active[p] &&
                      (r_inflight[p] < IW'(MAX_PER_PLAYER)) && w_any_free;
    end
  end

  always_comb begin
    w_winner = PLAYER_1;
    if (&w_eligible) begin
      w_winner = (r_last_grant == PLAYER_1) ? PLAYER_2 : PLAYER_1;
    end else if (w_eligible[1]) begin
      w_winner = PLAYER_2;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_offer = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i && (|w_eligible)) begin
          w_state_next = OFFER;
          w_load_offer = 1'b1;
        end
      end
      OFFER: begin
        // enable_i is deliberately ignored: an offer is never withdrawn.
        if (launch_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_player     <= PLAYER_1;
      r_slot       <= '0;
      r_last_grant <= PLAYER_2;
      r_shoot_q    <= '0;
      r_shoot_qq   <= '0;
      r_pending    <= '0;
      r_busy       <= '0;
      r_owner      <= '0;
      for (int p = 0; p < 2; p++) r_inflight[p] <= '0;
    end else begin
      r_state    <= w_state_next;
      r_shoot_q  <= {player_2_shoot_i, player_1_shoot_i};
      r_shoot_qq <= r_shoot_q;
      if (w_load_offer) begin
        r_player <= w_winner;
        r_slot   <= w_free_slot;
      end
      if (w_accept) r_last_grant <= r_player;
      for (int p = 0; p < 2; p++) begin
        if (!enable_i) r_pending[p] <= 1'b0;
        else if (w_inc[p]) r_pending[p] <= 1'b0;
        else if (w_rise[p]) r_pending[p] <= 1'b1;
        if (w_inc[p] && !w_dec[p] && (r_inflight[p] < IW'(MAX_PER_PLAYER)))
          r_inflight[p] <= r_inflight[p] + 1'b1;
        else if (w_dec[p] && !w_inc[p] && (r_inflight[p] != '0))
          r_inflight[p] <= r_inflight[p] - 1'b1;
      end
      // The offered slot is never busy, so retire and accept cannot collide.
      if (w_retire) r_busy[retire_slot_i] <= 1'b0;
      if (w_accept) begin
        r_busy[r_slot]  <= 1'b1;
        r_owner[r_slot] <= r_player;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_cool
    shot_cooldown #(.FRAMES(COOLDOWN_FRAMES)) u_cooldown (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (w_inc[g]),
      .tick_i  (frame_tick_i),
      .active_o(w_cool_active[g])
    );
  end

  assign launch_valid_o    = (r_state == OFFER);
  assign launch_player_o   = r_player;
  assign launch_slot_o     = r_slot;
  assign slot_busy_o       = r_busy;
  assign cooldown_active_o = w_cool_active;

endmodule

// File: tb/tb_shot_arbiter.sv
// tb/tb_shot_arbiter.sv - directed self-checking bench for shot_arbiter
module tb_shot_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i, enable_i, frame_tick_i;
  logic       player_1_shoot_i, player_2_shoot_i;
  logic       retire_valid_i, launch_ready_i;
  logic [1:0] retire_slot_i;
  logic       launch_valid_o, launch_player_o;
  logic [1:0] launch_slot_o;
  logic [3:0] slot_busy_o;
  logic [1:0] cooldown_active_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  shot_arbiter dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .frame_tick_i     (frame_tick_i),
    .player_1_shoot_i (player_1_shoot_i),
    .player_2_shoot_i (player_2_shoot_i),
    .retire_valid_i   (retire_valid_i),
    .retire_slot_i    (retire_slot_i),
    .launch_ready_i   (launch_ready_i),
    .launch_valid_o   (launch_valid_o),
    .launch_player_o  (launch_player_o),
    .launch_slot_o    (launch_slot_o),
    .slot_busy_o      (slot_busy_o),
    .cooldown_active_o(cooldown_active_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Key high for one edge (N), returns just after edge N+1.
  task automatic press(input logic p1, input logic p2);
    player_1_shoot_i = p1;
    player_2_shoot_i = p2;
    step(1);
    player_1_shoot_i = 1'b0;
    player_2_shoot_i = 1'b0;
    step(1);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick_i = 1'b1;
      step(1);
      frame_tick_i = 1'b0;
    end
  endtask

  task automatic accept();
    launch_ready_i = 1'b1;
    step(1);
    launch_ready_i = 1'b0;
  endtask

  task automatic retire(input logic [1:0] slot);
    retire_valid_i = 1'b1;
    retire_slot_i  = slot;
    step(1);
    retire_valid_i = 1'b0;
  endtask

  task automatic check_offer(input string tag, input logic p, input logic [1:0] s);
    check_eq(tag, {launch_valid_o, launch_player_o, launch_slot_o}, {1'b1, p, s});
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; frame_tick_i = 1'b0;
    player_1_shoot_i = 1'b0; player_2_shoot_i = 1'b0;
    retire_valid_i = 1'b0; retire_slot_i = 2'd0; launch_ready_i = 1'b0;
    step(2);
    reset_i = 1'b0;
    check_eq("reset_outputs", {launch_valid_o, launch_player_o, launch_slot_o,
             slot_busy_o, cooldown_active_o}, 32'h0);

    // First P1 press: valid at N+2
    press(1'b1, 1'b0);
    check_eq("latency_n1", launch_valid_o, 1'b0);
    step(1);
    check_offer("p1_first_offer", 1'b0, 2'd0);
    accept();
    check_eq("p1_busy", slot_busy_o, 4'b0001);
    check_eq("p1_cool", cooldown_active_o, 2'b01);
    check_eq("p1_valid_drop", launch_valid_o, 1'b0);

    // Simultaneous press after reset: P1 then P2
    reset_i = 1'b1; step(1); reset_i = 1'b0;
    press(1'b1, 1'b1);
    step(1);
    check_offer("tie_p1_first", 1'b0, 2'd0);
    accept();
    check_eq("tie_gap", launch_valid_o, 1'b0);
    step(1);
    check_offer("tie_p2_second", 1'b1, 2'd1);
    accept();
    check_eq("tie_busy", slot_busy_o, 4'b0011);
    check_eq("tie_cool", cooldown_active_o, 2'b11);

    // Cooldown boundary: 19 ticks still cooling, press held off
    frames(19);
    check_eq("cool_19", cooldown_active_o, 2'b11);
    press(1'b1, 1'b0);
    step(2);
    check_eq("cool_blocked", launch_valid_o, 1'b0);
    frames(1);
    check_eq("cool_20", cooldown_active_o, 2'b00);
    step(1);
    check_offer("cool_offer", 1'b0, 2'd2);
    accept();
    check_eq("cool_busy", slot_busy_o, 4'b0111);

    // In-flight limit: P1 owns slots 0 and 2
    frames(20);
    press(1'b1, 1'b0);
    step(2);
    check_eq("limit_blocked", launch_valid_o, 1'b0);
    retire(2'd0);
    check_eq("limit_retire_busy", slot_busy_o, 4'b0110);
    step(1);
    check_offer("limit_offer", 1'b0, 2'd0);
    accept();

    // Round-robin: last grant P1, tie now goes to P2
    retire(2'd2);
    check_eq("rr_busy", slot_busy_o, 4'b0011);
    frames(20);
    press(1'b1, 1'b1);
    step(1);
    check_offer("rr_p2_wins", 1'b1, 2'd2);
    accept();
    step(1);
    check_offer("rr_p1_next", 1'b0, 2'd3);

    // Offer held stable with ready low; enable drop does not withdraw
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable_i = 1'b0;
      step(1);
      check_offer("hold_stable", 1'b0, 2'd3);
    end
    accept();
    check_eq("hold_accept_busy", slot_busy_o, 4'b1111);
    check_eq("hold_accept_valid", launch_valid_o, 1'b0);
    enable_i = 1'b1;

    // Reset during OFFER
    reset_i = 1'b1; step(1); reset_i = 1'b0;
    press(1'b1, 1'b0);
    step(1);
    check_offer("rst_pre_offer", 1'b0, 2'd0);
    reset_i = 1'b1; step(1);
    check_eq("rst_mid_offer", {launch_valid_o, slot_busy_o, cooldown_active_o}, 32'h0);
    reset_i = 1'b0;

    // Press with enable low is not captured
    enable_i = 1'b0;
    player_1_shoot_i = 1'b1; step(1); player_1_shoot_i = 1'b0; step(1);
    enable_i = 1'b1;
    step(2);
    check_eq("disabled_press", launch_valid_o, 1'b0);

    // Same-cycle retire of slot 1 with accept of slot 2, both P1
    press(1'b0, 1'b1);
    step(1);
    check_offer("sc_p2_slot0", 1'b1, 2'd0);
    accept();
    press(1'b1, 1'b0);
    step(1);
    check_offer("sc_p1_slot1", 1'b0, 2'd1);
    accept();
    frames(20);
    press(1'b1, 1'b0);
    step(1);
    check_offer("sc_p1_slot2", 1'b0, 2'd2);
    launch_ready_i = 1'b1; retire_valid_i = 1'b1; retire_slot_i = 2'd1;
    step(1);
    launch_ready_i = 1'b0; retire_valid_i = 1'b0;
    check_eq("sc_busy", slot_busy_o, 4'b0101);
    frames(20);
    press(1'b1, 1'b0);
    step(1);
    check_offer("sc_inflight_one", 1'b0, 2'd1);
    accept();
    frames(20);
    press(1'b1, 1'b0);
    step(2);
    check_eq("sc_inflight_two", launch_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
